button_events: RTL
==================

// Module: button_events
// PURPOSE
//   Input-side counterpart of the LED drivers: conditions a raw board push-button
//   into clean, single-cycle events. 2-FF synchronizer, debounce FSM, press/release/
//   long-press pulses, level output and a wrapping press counter. One instance per
//   button, between the pad and the application logic, all on sys_clk.
// PARAMETERS
//   DEBOUNCE_CYCLES  270000    (10 ms @ 27 MHz) stable cycles needed to accept a level change; >= 2
//   LONG_CYCLES      27000000  (1 s) press duration that fires btn_long; > DEBOUNCE_CYCLES
//   ACTIVE_LOW       1         1: pad reads 0 when pressed (board default); 0: active high
// PORTS
//   sys_clk      in   1  system clock
//   sys_reset    in   1  asynchronous reset, active high
//   btn          in   1  raw, asynchronous button pad
//   btn_level    out  1  debounced state, 1 = pressed
//   btn_press    out  1  one-cycle pulse on accepted press
//   btn_release  out  1  one-cycle pulse on accepted release
//   btn_long     out  1  one-cycle pulse once per press when hold reaches LONG_CYCLES
//   press_count  out  8  number of accepted presses, mod 256
// BEHAVIOUR
//   - Reset (async, all flops): sync FFs = inactive pad level (~ACTIVE_LOW... i.e. ACTIVE_LOW?1:0),
//     state RELEASED, counters 0, all outputs 0.
//   - pressed = sync_q XOR ACTIVE_LOW (normalised, 1 = pressed).
//   - Counters: db_cnt width $clog2(DEBOUNCE_CYCLES); hold_cnt width $clog2(LONG_CYCLES+1), saturating.
//   - FSM:
//     RELEASED   : pressed -> DB_PRESS, db_cnt=0.
//     DB_PRESS   : !pressed -> RELEASED (bounce, no event); db_cnt==DEBOUNCE_CYCLES-1 -> PRESSED,
//                  btn_level=1, btn_press=1, press_count++, hold_cnt=0; else db_cnt++.
//     PRESSED    : hold_cnt++ (saturate at LONG_CYCLES); btn_long=1 in the cycle hold_cnt hits
//                  LONG_CYCLES-1, never again this press; !pressed -> DB_RELEASE, db_cnt=0.
//     DB_RELEASE : pressed -> PRESSED (bounce, no event, hold_cnt frozen then resumes);
//                  db_cnt==DEBOUNCE_CYCLES-1 -> RELEASED, btn_level=0, btn_release=1; else db_cnt++.
//   - Latency: raw edge first sampled at edge N -> btn_press/btn_release high in cycle after
//     edge N+2+DEBOUNCE_CYCLES, provided btn stays stable.
//   - Pulses are registered, exactly one cycle wide; btn_long and btn_release never coincide
//     (release needs DB_RELEASE first). A glitch shorter than DEBOUNCE_CYCLES yields no event.
//   - press_count wraps 255 -> 0 silently.
//   - Reset mid-press: outputs drop to 0 immediately, no btn_release emitted; if btn is still
//     held after reset deassertion, a fresh btn_press follows after the normal latency.
// CONFIGURATION
//   BUTTON_LONG_PRESS_EN defined: hold_cnt and btn_long logic present as above.
//   Not defined: hold_cnt removed, btn_long tied 0, LONG_CYCLES ignored; all else identical.
// STRUCTURE
//   - Shared header button_pkg.vh: FSM state localparams (RELEASED=2'd0, DB_PRESS=2'd1,
//     PRESSED=2'd2, DB_RELEASE=2'd3) and CLK_HZ=27000000 for default derivation.
//   - One sub-module: sync_2ff (parameter RESET_VAL), reusable for any pad input.
//   - FSM, counters and output registers stay in button_events.
// TESTING (bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1)
//   1. btn 1->0 held 40 cycles -> btn_press 1 cycle at edge N+10, btn_long 1 cycle 32 cycles later, press_count=1.
//   2. btn pulses low for 5 cycles then high -> no pulses, btn_level stays 0, press_count=0.
//   3. Press accepted, release with 3-cycle bounce (0/1/0/1) then stable 1 -> one btn_release only,
//      btn_level 0 exactly 8 cycles after last bounce + 2 sync cycles.
//   4. 256 clean press/release cycles -> press_count returns to 0, 256 press and 256 release pulses.
//   5. sys_reset asserted mid-PRESSED with btn held, released 3 cycles later -> outputs 0 during
//      reset, no btn_release, new btn_press 10 cycles after reset drop.
//   6. Build without BUTTON_LONG_PRESS_EN, hold 100 cycles -> btn_long never asserted; press/release as in 1.

Source files
------------

// File: rtl/button_events_pkg.sv
// Shared definitions for the button conditioning block.
//   CLK_HZ      : board system clock, used to derive default timings
//   btn_state_e : debounce FSM states (encodings fixed for debug visibility)
package button_events_pkg;

  localparam int CLK_HZ = 27_000_000;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_e;

endpackage

// File: rtl/button_events_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous pad input.
//   clk_i     : destination clock
//   rst_i     : asynchronous reset, active high
//   d_i       : asynchronous input
//   q_o       : synchronized output (two cycles of latency)
// RESET_VAL sets both flops, so a pad's idle level can be used and no
// spurious edge is seen after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= {2{RESET_VAL}};
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/button_events.sv
// button_events: turns a raw push-button pad into clean single-cycle events.
//   sys_clk      : system clock
//   sys_reset    : asynchronous reset, active high
//   btn          : raw asynchronous pad
//   btn_level    : debounced state, 1 = pressed
//   btn_press    : one-cycle pulse on an accepted press
//   btn_release  : one-cycle pulse on an accepted release
//   btn_long     : one-cycle pulse once per press when the hold reaches LONG_CYCLES
//   press_count  : accepted presses, wraps mod 256
// Build option: define BUTTON_LONG_PRESS_EN to include the hold counter and
// btn_long; otherwise btn_long is tied low and LONG_CYCLES is only range-checked.
module button_events
  import button_events_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = CLK_HZ / 100,
  parameter int LONG_CYCLES     = CLK_HZ,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       btn,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_long,
  output logic [7:0] press_count
);

  localparam int              DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0]  DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end

  logic btn_sync;
  logic pressed;

  // Sync flops start at the idle pad level so reset never looks like a press.
  sync_2ff #(.RESET_VAL(logic'(ACTIVE_LOW))) u_sync (
    .clk_i (sys_clk),
    .rst_i (sys_reset),
    .d_i   (btn),
    .q_o   (btn_sync)
  );

  assign pressed = btn_sync ^ ACTIVE_LOW;

  btn_state_e     state_q;
  logic [DBW-1:0] db_cnt_q;
  logic           level_q, press_q, release_q;
  logic [7:0]     count_q;

  // Any sample disagreeing with the candidate level during debounce falls
  // back to the settled state without an event.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q   <= RELEASED;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        RELEASED: if (pressed) begin
          state_q  <= DB_PRESS;
          db_cnt_q <= '0;
        end
        DB_PRESS: begin
          if (!pressed) state_q <= RELEASED;
          else if (db_cnt_q == DB_LAST) begin
            state_q <= PRESSED;
            level_q <= 1'b1;
            press_q <= 1'b1;
            count_q <= count_q + 8'd1;
          end else db_cnt_q <= db_cnt_q + DBW'(1);
        end
        PRESSED: if (!pressed) begin
          state_q  <= DB_RELEASE;
          db_cnt_q <= '0;
        end
        DB_RELEASE: begin
          if (pressed) state_q <= PRESSED;
          else if (db_cnt_q == DB_LAST) begin
            state_q   <= RELEASED;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else db_cnt_q <= db_cnt_q + DBW'(1);
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int             HW        = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0]  HOLD_FIRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt_q;
  logic          long_q;

  // Counts only in PRESSED, so release bounces freeze it. Saturation past
  // HOLD_FIRE guarantees a single btn_long per press.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state_q == DB_PRESS && pressed && db_cnt_q == DB_LAST) begin
        hold_cnt_q <= '0;
      end else if (state_q == PRESSED) begin
        if (hold_cnt_q == HOLD_FIRE) long_q <= 1'b1;
        if (hold_cnt_q != HOLD_MAX)  hold_cnt_q <= hold_cnt_q + HW'(1);
      end
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign press_count = count_q;

endmodule
